// File: rtl/alu_pkg.sv
// Shared ALU definitions: adder/subtractor FSM states
// and operation encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the multi-cycle adder: plain ripple
// add, plus the carry into the slice MSB for overflow detection.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] sum;

  assign sum = {1'b0, x}
             + {1'b0, y}
             + {{CHUNK{1'b0}}, cin};

  assign s    = sum[CHUNK-1:0];
  assign cout = sum[CHUNK];

  // MSB sum bit = x ^ y ^ carry-in, so the carry-in falls out.
  assign c_msb_in = x[CHUNK-1]
                  ^ y[CHUNK-1]
                  ^ sum[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle two's-complement adder/subtractor processing
// CHUNK bits per cycle, with valid/ready on both sides.
module addsub_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH ||
      (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("addsub_multicycle: bad WIDTH/CHUNK");
  end

  addsub_state_t    state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [CHUNK-1:0] s;
  logic             cout;
  logic             c_msb_in;
  logic [WIDTH-1:0] full_d;

  addsub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x        (a_q[CHUNK-1:0]),
    .y        (b_q[CHUNK-1:0]),
    .cin      (c_q),
    .s        (s),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  // Partial sums accumulate in the upper bits; the final chunk
  // lands on top, so full_d is only meaningful on the last cycle.
  if (N > 1) begin : g_acc
    logic [WIDTH-CHUNK-1:0] acc_q;

    assign full_d = {s, acc_q};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (state_q == BUSY) begin
        acc_q <= full_d[WIDTH-1:CHUNK];
      end
    end
  end else begin : g_noacc
    assign full_d = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (sub == OP_SUB) ? ~b : b;
            c_q     <= sub;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          a_q <= a_q >> CHUNK;
          b_q <= b_q >> CHUNK;
          c_q <= cout;
          if (cnt_q == LAST) begin
            result_q <= full_d;
            carry_q  <= cout;
            ovf_q    <= cout ^ c_msb_in;
            zero_q   <= (full_d == '0);
            neg_q    <= full_d[WIDTH-1];
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Scoreboard bench: three instances (CHUNK 8, 32, 1) share
// stimulus; per-instance monitors check results and latency.
module tb_addsub_multicycle;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;

  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [31:0] res_w [3];
  logic [2:0]  carry_w;
  logic [2:0]  ovf_w;
  logic [2:0]  zero_w;
  logic [2:0]  neg_w;

  exp_t expq [3][$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 1);

    addsub_multicycle #(
      .WIDTH(32),
      .CHUNK(CH)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .result    (res_w[g]),
      .carry     (carry_w[g]),
      .ovf       (ovf_w[g]),
      .zero      (zero_w[g]),
      .neg       (neg_w[g])
    );

    logic ov_prev = 1'b0;
    int   acc_cyc = 0;
    exp_t e;

    always @(negedge clk) begin
      if (!rst_n) begin
        ov_prev = 1'b0;
      end else begin
        if (in_valid && in_ready_w[g])
          acc_cyc = cyc + 1;
        if (out_valid_w[g] && !ov_prev)
          chk($sformatf("latency_c%0d", CH),
              64'(cyc - acc_cyc), 64'(32 / CH));
        if (out_valid_w[g] && out_ready) begin
          if (expq[g].size() == 0) begin
            chk($sformatf("unexpected_out_c%0d", CH),
                64'd1, 64'd0);
          end else begin
            e = expq[g].pop_front();
            chk($sformatf("result_c%0d", CH),
                64'(res_w[g]), 64'(e.r));
            chk($sformatf("flags_cozn_c%0d", CH),
                {60'd0, carry_w[g], ovf_w[g],
                 zero_w[g], neg_w[g]},
                {60'd0, e.c, e.o, e.z, e.n});
          end
        end
        ov_prev = out_valid_w[g];
      end
    end
  end

  task automatic check_reset_vals(string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_in_ready%0d", tag, g),
          64'(in_ready_w[g]), 64'd1);
      chk($sformatf("%s_out_valid%0d", tag, g),
          64'(out_valid_w[g]), 64'd0);
      chk($sformatf("%s_outs%0d", tag, g),
          {28'd0, res_w[g], carry_w[g], ovf_w[g],
           zero_w[g], neg_w[g]}, 64'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready_w != 3'b111 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready_w != 3'b111)
      chk("timeout_idle", 64'(in_ready_w), 64'h7);
  endtask

  task automatic issue(logic [31:0] ta, logic [31:0] tb,
                       logic ts, exp_t e, bit push);
    wait_idle();
    if (push)
      for (int g = 0; g < 3; g++) expq[g].push_back(e);
    a = ta;
    b = tb;
    sub = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((expq[0].size() + expq[1].size() +
            expq[2].size()) != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("timeout_drain",
        64'(expq[0].size() + expq[1].size() +
            expq[2].size()), 64'd0);
  endtask

  task automatic run_op(logic [31:0] ta, logic [31:0] tb,
                        logic ts, exp_t e);
    issue(ta, tb, ts, e, 1'b1);
    wait_drained();
  endtask

  exp_t stall_e;

  initial begin
    #3;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op(32'd5, 32'd3, 1'b1,
           '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0});
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
           '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1,
           '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1,
           '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
           '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1});

    // Back-pressure: result must hold while out_ready is low.
    stall_e = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, stall_e, 1'b1);
    begin
      int n = 0;
      while (out_valid_w != 3'b111 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("timeout_stall_valid", 64'(out_valid_w), 64'h7);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        a = 32'd7;
        b = 32'd9;
        sub = 1'b0;
        in_valid = 1'b1;
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("stall_result%0d", g),
            64'(res_w[g]), 64'(stall_e.r));
        chk($sformatf("stall_flags%0d", g),
            {60'd0, carry_w[g], ovf_w[g],
             zero_w[g], neg_w[g]}, 64'b1010);
        chk($sformatf("stall_ready_valid%0d", g),
            {62'd0, in_ready_w[g], out_valid_w[g]}, 64'b01);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(in_ready_w), 64'h7);
    chk("release_out_valid", 64'(out_valid_w), 64'h0);
    wait_drained();

    // Abort mid-BUSY: nothing may ever come out.
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, stall_e, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_valid", 64'(out_valid_w), 64'h0);

    run_op(32'd1, 32'd1, 1'b0,
           '{32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
